// File: rtl/e203_itcm_ctrl_pkg.sv
// ============================================================================
// Module   : e203_itcm_ctrl_pkg
// Purpose  : Shared types and default widths for the ITCM controller slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package e203_itcm_ctrl_pkg;

    localparam int C_AW = 13;
    localparam int C_DW = 64;
    localparam int C_MW = C_DW / 8;

    typedef enum logic [1:0] {
        PWR_RUN   = 2'd0,
        PWR_SLEEP = 2'd1,
        PWR_WAKE  = 2'd2
    } pwr_state_t;

    // Values double as bit positions in the one-hot grant vector
    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/e203_itcm_ctrl_if.sv
// ============================================================================
// Module   : e203_itcm_ctrl_if
// Purpose  : IFU fetch and LSU load/store command/response ports of the ITCM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface e203_itcm_ctrl_if
    import e203_itcm_ctrl_pkg::*;
#(
    parameter int AW = C_AW,
    parameter int DW = C_DW,
    parameter int MW = C_MW
);
    logic          ifu_cmd_valid;
    logic          ifu_cmd_ready;
    logic [AW-1:0] ifu_cmd_addr;
    logic          ifu_rsp_valid;
    logic          ifu_rsp_ready;
    logic [DW-1:0] ifu_rsp_rdata;

    logic          lsu_cmd_valid;
    logic          lsu_cmd_ready;
    logic          lsu_cmd_read;
    logic [AW-1:0] lsu_cmd_addr;
    logic [DW-1:0] lsu_cmd_wdata;
    logic [MW-1:0] lsu_cmd_wmask;
    logic          lsu_rsp_valid;
    logic          lsu_rsp_ready;
    logic [DW-1:0] lsu_rsp_rdata;

    modport master (
        output ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
        output lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata,
        output lsu_cmd_wmask, lsu_rsp_ready,
        input  ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata,
        input  lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata
    );

    modport slave (
        input  ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
        input  lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata,
        input  lsu_cmd_wmask, lsu_rsp_ready,
        output ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata,
        output lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata
    );

endinterface

`default_nettype wire

// File: rtl/e203_itcm_arb.sv
// ============================================================================
// Module   : e203_itcm_arb
// Purpose  : LSU-priority arbiter with IFU starvation guard, one-hot grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module e203_itcm_arb
    import e203_itcm_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       en,
    input  wire logic       ifu_valid,
    input  wire logic       lsu_valid,
    output logic            ifu_ready,
    output logic            lsu_ready,
    output logic [1:0]      grant
);

    localparam int C_SW = $clog2(STARVE_MAX + 1);

    logic [C_SW-1:0] r_starve_cnt;
    logic            w_force_ifu;

    assign w_force_ifu = (r_starve_cnt == C_SW'(STARVE_MAX));

    // Readies depend only on the other side's valid, never on their own
    assign ifu_ready = en & (~lsu_valid | w_force_ifu);
    assign lsu_ready = en & ~(ifu_valid & w_force_ifu);

    assign grant[REQ_IFU] = ifu_ready & ifu_valid;
    assign grant[REQ_LSU] = lsu_ready & lsu_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!ifu_valid || grant[REQ_IFU]) begin
            r_starve_cnt <= '0;
        end else if (grant[REQ_LSU] && !w_force_ifu) begin
            r_starve_cnt <= r_starve_cnt + C_SW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/e203_itcm_ctrl.sv
// ============================================================================
// Module   : e203_itcm_ctrl
// Purpose  : ITCM RAM sequencer: IFU/LSU sharing, stalled responses, light sleep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module e203_itcm_ctrl
    import e203_itcm_ctrl_pkg::*;
#(
    parameter int AW          = C_AW,
    parameter int DW          = C_DW,
    parameter int MW          = C_MW,
    parameter int IDLE_LS_CYC = 16,
    parameter int STARVE_MAX  = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          pwr_sd,
    input  wire logic          pwr_ds,
    e203_itcm_ctrl_if.slave    bus,
    output logic               ram_sd,
    output logic               ram_ds,
    output logic               ram_ls,
    output logic               ram_cs,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [MW-1:0]      ram_wem,
    output logic [DW-1:0]      ram_din,
    input  wire logic [DW-1:0] ram_dout
);

    localparam int C_IW = $clog2(IDLE_LS_CYC);

    pwr_state_t      r_pwr_state;
    pwr_state_t      w_pwr_state_nxt;
    logic [C_IW-1:0] r_idle_cnt;
    logic [C_IW-1:0] w_idle_cnt_nxt;

    logic            r_active;
    logic            r_rsp_pending;
    req_id_t         r_rsp_owner;
    logic            r_rsp_read;
    logic            r_hold_valid;
    logic [DW-1:0]   r_hold_data;

    logic            w_rsp_ready;
    logic            w_rsp_stall;
    logic            w_arb_en;
    logic [1:0]      w_grant;
    logic            w_any_grant;
    logic            w_lsu_write;
    logic            w_any_valid;
    logic            w_busy;
    logic [DW-1:0]   w_rsp_data;
    logic            w_ifu_rsp_valid;
    logic            w_lsu_rsp_valid;

    assign ram_sd = pwr_sd;
    assign ram_ds = pwr_ds;

    // Holds readies low for the first cycle out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    assign w_rsp_ready = (r_rsp_owner == REQ_IFU) ? bus.ifu_rsp_ready : bus.lsu_rsp_ready;
    assign w_rsp_stall = r_rsp_pending & ~w_rsp_ready;
    assign w_arb_en    = r_active & (r_pwr_state == PWR_RUN) & ~pwr_sd & ~pwr_ds & ~w_rsp_stall;

    e203_itcm_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_arb_en),
        .ifu_valid (bus.ifu_cmd_valid),
        .lsu_valid (bus.lsu_cmd_valid),
        .ifu_ready (bus.ifu_cmd_ready),
        .lsu_ready (bus.lsu_cmd_ready),
        .grant     (w_grant)
    );

    assign w_any_grant = |w_grant;
    assign w_lsu_write = w_grant[REQ_LSU] & ~bus.lsu_cmd_read;

    assign ram_cs   = w_any_grant;
    assign ram_we   = w_lsu_write;
    assign ram_wem  = w_lsu_write ? bus.lsu_cmd_wmask : '0;
    assign ram_din  = w_grant[REQ_LSU] ? bus.lsu_cmd_wdata : '0;
    assign ram_addr = w_grant[REQ_LSU] ? bus.lsu_cmd_addr :
                      (w_grant[REQ_IFU] ? bus.ifu_cmd_addr : '0);

    // Once stalled, RAM output is no longer trusted; serve the captured copy
    assign w_rsp_data = r_hold_valid ? r_hold_data : (r_rsp_read ? ram_dout : '0);

    assign w_ifu_rsp_valid   = r_rsp_pending & (r_rsp_owner == REQ_IFU);
    assign w_lsu_rsp_valid   = r_rsp_pending & (r_rsp_owner == REQ_LSU);
    assign bus.ifu_rsp_valid = w_ifu_rsp_valid;
    assign bus.lsu_rsp_valid = w_lsu_rsp_valid;
    assign bus.ifu_rsp_rdata = w_ifu_rsp_valid ? w_rsp_data : '0;
    assign bus.lsu_rsp_rdata = w_lsu_rsp_valid ? w_rsp_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_pending <= 1'b0;
            r_rsp_owner   <= REQ_IFU;
            r_rsp_read    <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_hold_data   <= '0;
        end else if (w_rsp_stall) begin
            if (!r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= w_rsp_data;
            end
        end else begin
            r_hold_valid  <= 1'b0;
            r_rsp_pending <= w_any_grant;
            if (w_any_grant) begin
                r_rsp_owner <= w_grant[REQ_LSU] ? REQ_LSU : REQ_IFU;
                r_rsp_read  <= ~w_lsu_write;
            end
        end
    end

    assign w_any_valid = bus.ifu_cmd_valid | bus.lsu_cmd_valid;
    assign w_busy      = w_any_grant | r_rsp_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwr_state <= PWR_RUN;
            r_idle_cnt  <= '0;
        end else begin
            r_pwr_state <= w_pwr_state_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
        end
    end

    // Sleep is entered on the edge that completes IDLE_LS_CYC idle cycles
    always_comb begin
        w_pwr_state_nxt = r_pwr_state;
        w_idle_cnt_nxt  = '0;
        ram_ls          = 1'b0;
        case (r_pwr_state)
            PWR_RUN: begin
                if (!w_busy) begin
                    if (r_idle_cnt == C_IW'(IDLE_LS_CYC - 1)) begin
                        w_pwr_state_nxt = PWR_SLEEP;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + C_IW'(1);
                    end
                end
            end
            PWR_SLEEP: begin
                ram_ls = 1'b1;
                if (w_any_valid) begin
                    w_pwr_state_nxt = PWR_WAKE;
                end
            end
            PWR_WAKE: begin
                w_pwr_state_nxt = PWR_RUN;
            end
            default: begin
                w_pwr_state_nxt = PWR_RUN;
            end
        endcase
    end

endmodule

`default_nettype wire
